// File: rtl/spike_pkg.sv
// Shared register map, control bit positions and FSM state type for the
// spike scheduler peripheral.
package spike_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned BUS_W  = 8;

  localparam logic [ADDR_W-1:0] ADDR_IN0    = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_IN1    = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_IN2    = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_IN3    = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_THRESH = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'h5;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD = 4'h6;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'h7;
  localparam logic [ADDR_W-1:0] ADDR_ACC0   = 4'h8;
  localparam logic [ADDR_W-1:0] ADDR_ACC1   = 4'h9;
  localparam logic [ADDR_W-1:0] ADDR_ACC2   = 4'hA;
  localparam logic [ADDR_W-1:0] ADDR_ACC3   = 4'hB;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_CLR  = 1;
  localparam int unsigned CTRL_EXT  = 2;
  localparam int unsigned CTRL_BUSY = 7;

  localparam logic [BUS_W-1:0] THRESH_RST = 8'd100;

  typedef enum logic [1:0] {IDLE, WAIT, SCAN, DONE} state_t;

endpackage

// File: rtl/spike_scheduler_if.sv
// Peripheral register bus between the host core and the spike scheduler.
interface spike_scheduler_if;
  import spike_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              data_write;
  logic [BUS_W-1:0]  data_in;
  logic [BUS_W-1:0]  data_out;

  modport master (output address, output data_write, output data_in, input data_out);
  modport slave  (input address, input data_write, input data_in, output data_out);

endinterface

// File: rtl/spike_lif_unit.sv
// Shared integrate-and-fire datapath: saturating accumulate and threshold
// compare for whichever channel the scheduler is currently scanning.
module spike_lif_unit #(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] in,
  input  logic [DW-1:0] thresh,
  output logic [DW-1:0] sum,
  output logic          fire
);

  logic [DW:0] raw;

  assign raw  = {1'b0, acc} + {1'b0, in};
  assign sum  = raw[DW] ? {DW{1'b1}} : raw[DW-1:0];
  // A zero threshold disables firing while the accumulator keeps integrating.
  assign fire = (thresh != '0) && (sum >= thresh);

endmodule

// File: rtl/spike_scheduler.sv
// Round-robin spike-encoding sequencer: sweeps NUM_CH channels through one
// shared integrate-and-fire unit per frame and exposes config/status registers.
module spike_scheduler
  import spike_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DW     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         ui_in,
  output logic [7:0]         uo_out,
  spike_scheduler_if.slave   bus
);

  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t            state, state_nxt;
  logic [DW-1:0]     cnt, cnt_nxt;
  logic [CHW-1:0]    ch, ch_nxt;

  logic [DW-1:0]     in_r [NUM_CH];
  logic [DW-1:0]     acc  [NUM_CH];
  logic [DW-1:0]     thresh;
  logic [DW-1:0]     period;
  logic              en;
  logic              ext;
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] frame_vec;
  logic [NUM_CH-1:0] spikes;

  logic              busy;
  logic              wr_ctrl;
  logic              clr;
  logic              scan_act;
  logic              done_act;
  logic [NUM_CH-1:0] w1c;
  logic [DW-1:0]     lif_sum;
  logic              lif_fire;
  logic [BUS_W-1:0]  rd_data;
  logic              unused_ui;

  assign unused_ui = ^ui_in[7:1];

  assign busy     = (state == SCAN) || (state == DONE);
  assign wr_ctrl  = bus.data_write && (bus.address == ADDR_CTRL);
  assign clr      = wr_ctrl && bus.data_in[CTRL_CLR];
  assign scan_act = en && (state == SCAN);
  assign done_act = en && (state == DONE);
  assign w1c      = (bus.data_write && (bus.address == ADDR_STATUS)) ?
                    bus.data_in[NUM_CH-1:0] : '0;

  spike_lif_unit #(.DW(DW)) u_lif (
    .acc    (acc[ch]),
    .in     (in_r[ch]),
    .thresh (thresh),
    .sum    (lif_sum),
    .fire   (lif_fire)
  );

  // Frame sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ch    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ch    <= ch_nxt;
    end
  end

  // Next-state: disable dominates every state; WAIT compares against live PERIOD.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ch_nxt    = '0;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
        WAIT: begin
          if (ext ? ui_in[0] : (cnt >= period)) begin
            state_nxt = SCAN;
          end else if (!ext) begin
            cnt_nxt = cnt + DW'(1);
          end
        end
        SCAN: begin
          if (32'(ch) == NUM_CH - 1) begin
            state_nxt = DONE;
          end else begin
            ch_nxt = ch + CHW'(1);
          end
        end
        DONE: begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Register file, accumulators and spike/status capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        in_r[i] <= '0;
        acc[i]  <= '0;
      end
      thresh    <= DW'(THRESH_RST);
      period    <= '0;
      en        <= 1'b0;
      ext       <= 1'b0;
      status    <= '0;
      frame_vec <= '0;
      spikes    <= '0;
    end else begin
      if (bus.data_write) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (bus.address == ADDR_W'(ADDR_IN0 + i)) in_r[i] <= DW'(bus.data_in);
        end
        case (bus.address)
          ADDR_THRESH: thresh <= DW'(bus.data_in);
          ADDR_PERIOD: period <= DW'(bus.data_in);
          ADDR_CTRL: begin
            en  <= bus.data_in[CTRL_EN];
            ext <= bus.data_in[CTRL_EXT];
          end
          default: ;
        endcase
      end

      // Bits fired this frame survive a simultaneous clear.
      status <= (status & ~w1c) | (done_act ? frame_vec : '0);

      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (clr) begin
          acc[i] <= '0;
        end else if (scan_act && (32'(ch) == i)) begin
          acc[i] <= lif_fire ? '0 : lif_sum;
        end
      end

      if (!en) begin
        frame_vec <= '0;
        spikes    <= '0;
      end else begin
        if (scan_act) frame_vec[ch] <= lif_fire;
        if (done_act) spikes <= frame_vec;
      end
    end
  end

  // Register read mux; unimplemented and out-of-range channel addresses read 0.
  always_comb begin
    rd_data = '0;
    case (bus.address)
      ADDR_THRESH: rd_data = BUS_W'(thresh);
      ADDR_PERIOD: rd_data = BUS_W'(period);
      ADDR_STATUS: rd_data = BUS_W'(status);
      ADDR_CTRL: begin
        rd_data[CTRL_BUSY] = busy;
        rd_data[CTRL_EXT]  = ext;
        rd_data[CTRL_EN]   = en;
      end
      default: ;
    endcase
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.address == ADDR_W'(ADDR_IN0 + i))  rd_data = BUS_W'(in_r[i]);
      if (bus.address == ADDR_W'(ADDR_ACC0 + i)) rd_data = BUS_W'(acc[i]);
    end
  end

  assign bus.data_out = rd_data;
  assign uo_out       = {busy, 7'(spikes)};

endmodule

// File: tb/tb_spike_scheduler.sv
// Directed bench for spike_scheduler: cycle-exact frame timing, saturation,
// status W1C races, external trigger, disable and mid-frame reset.
module tb_spike_scheduler;
  import spike_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  int         vectors;
  int         errors;
  int         n;
  int         nb;

  spike_scheduler_if bus_if ();

  spike_scheduler #(.NUM_CH(4), .DW(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus_if.address    = a;
    bus_if.data_in    = d;
    bus_if.data_write = 1'b1;
    tick();
    bus_if.data_write = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
    bus_if.address = a;
    #1;
    chk(tag, bus_if.data_out, exp);
  endtask

  task automatic wait_busy(input logic lvl);
    int k = 0;
    while (uo_out[7] !== lvl && k < 50) begin
      tick();
      k++;
    end
    if (uo_out[7] !== lvl) begin
      vectors++;
      errors++;
      $error("FAIL busy_timeout observed=%0b expected=%0b", uo_out[7], lvl);
    end
  endtask

  task automatic frame();
    wait_busy(1'b1);
    wait_busy(1'b0);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    ui_in   = 8'h00;
    bus_if.address    = 4'h0;
    bus_if.data_in    = 8'h00;
    bus_if.data_write = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Post-reset state
    chk("rst_uo", uo_out, 8'h00);
    chk_reg("rst_thresh", ADDR_THRESH, 8'd100);
    chk_reg("rst_ctrl", ADDR_CTRL, 8'h00);
    chk_reg("rst_acc0", ADDR_ACC0, 8'h00);

    // Basic integrate/fire, PERIOD=0 gives a 6-cycle frame
    wr(ADDR_IN0, 8'd60);
    wr(ADDR_PERIOD, 8'd0);
    wr(ADDR_CTRL, 8'h01);
    tick();
    tick();
    chk("first_scan_busy", uo_out, 8'h80);
    n = 0;
    while (uo_out[7] == 1'b1 && n < 20) begin tick(); n++; end
    chk("f1_no_spike", uo_out, 8'h00);
    chk_reg("f1_acc0", ADDR_ACC0, 8'd60);
    while (uo_out[7] == 1'b0 && n < 20) begin tick(); n++; end
    chk("frame_len_p0", 8'(n), 8'd6);
    repeat (4) tick();
    chk("done_busy", uo_out, 8'h80);
    tick();
    chk("f2_spike", uo_out, 8'h01);
    chk_reg("f2_acc0", ADDR_ACC0, 8'h00);
    chk_reg("f2_status", ADDR_STATUS, 8'h01);

    // THRESH=0: integrate and saturate, never fire; PERIOD=2 frame length
    wr(ADDR_CTRL, 8'h02);
    tick();
    chk("dis_uo", uo_out, 8'h00);
    wr(ADDR_STATUS, 8'hFF);
    wr(ADDR_IN1, 8'd200);
    wr(ADDR_THRESH, 8'd0);
    wr(ADDR_PERIOD, 8'd2);
    wr(ADDR_CTRL, 8'h01);
    frame();
    chk_reg("sat_acc1_f1", ADDR_ACC1, 8'd200);
    frame();
    chk_reg("sat_acc1_f2", ADDR_ACC1, 8'hFF);
    chk_reg("sat_acc0_f2", ADDR_ACC0, 8'd120);
    chk("sat_uo", uo_out, 8'h00);
    chk_reg("sat_status", ADDR_STATUS, 8'h00);
    wait_busy(1'b1);
    n = 0;
    while (uo_out[7] == 1'b1 && n < 30) begin tick(); n++; end
    while (uo_out[7] == 1'b0 && n < 30) begin tick(); n++; end
    chk("frame_len_p2", 8'(n), 8'd8);

    // STATUS W1C colliding with DONE set
    wr(ADDR_CTRL, 8'h02);
    tick();
    wr(ADDR_STATUS, 8'h0F);
    wr(ADDR_PERIOD, 8'd0);
    wr(ADDR_THRESH, 8'd100);
    wr(ADDR_IN0, 8'd0);
    wr(ADDR_IN1, 8'd0);
    wr(ADDR_IN2, 8'd100);
    wr(ADDR_CTRL, 8'h01);
    repeat (6) tick();
    chk("w1c_in_done", uo_out, 8'h80);
    wr(ADDR_STATUS, 8'h04);
    chk_reg("w1c_set_wins", ADDR_STATUS, 8'h04);
    chk("w1c_spike", uo_out, 8'h04);
    wr(ADDR_STATUS, 8'h04);
    chk_reg("w1c_clears", ADDR_STATUS, 8'h00);

    // External trigger: hold in WAIT without pulse, one frame per pulse
    wr(ADDR_CTRL, 8'h00);
    tick();
    wr(ADDR_STATUS, 8'h0F);
    wr(ADDR_CTRL, 8'h05);
    nb = 0;
    repeat (20) begin tick(); if (uo_out[7]) nb++; end
    chk("ext_hold_busy", 8'(nb), 8'd0);
    chk("ext_hold_uo", uo_out, 8'h00);
    ui_in = 8'h01;
    tick();
    ui_in = 8'h00;
    nb = uo_out[7] ? 1 : 0;
    repeat (20) begin tick(); if (uo_out[7]) nb++; end
    chk("ext_one_frame", 8'(nb), 8'd5);
    chk_reg("ext_status", ADDR_STATUS, 8'h04);
    chk("ext_uo", uo_out, 8'h04);

    // Disable during SCAN of channel 1
    wr(ADDR_CTRL, 8'h02);
    tick();
    wr(ADDR_STATUS, 8'h0F);
    wr(ADDR_IN0, 8'd10);
    wr(ADDR_IN1, 8'd20);
    wr(ADDR_IN2, 8'd30);
    wr(ADDR_IN3, 8'd100);
    wr(ADDR_CTRL, 8'h01);
    frame();
    chk("dis_pre_uo", uo_out, 8'h08);
    tick();
    tick();
    wr(ADDR_CTRL, 8'h00);
    tick();
    chk("dis_idle_uo", uo_out, 8'h00);
    chk_reg("dis_acc0", ADDR_ACC0, 8'd20);
    chk_reg("dis_acc2", ADDR_ACC2, 8'd30);
    chk_reg("dis_acc3", ADDR_ACC3, 8'd0);
    chk_reg("dis_ctrl", ADDR_CTRL, 8'h00);
    chk_reg("dis_status", ADDR_STATUS, 8'h08);

    // Asynchronous reset mid-SCAN
    wr(ADDR_CTRL, 8'h01);
    tick();
    tick();
    tick();
    chk("pre_rst_uo", uo_out, 8'h80);
    chk_reg("pre_rst_acc0", ADDR_ACC0, 8'd30);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_uo", uo_out, 8'h00);
    chk_reg("mid_rst_thresh", ADDR_THRESH, 8'd100);
    chk_reg("mid_rst_acc0", ADDR_ACC0, 8'h00);
    chk_reg("mid_rst_acc1", ADDR_ACC1, 8'h00);
    chk_reg("mid_rst_ctrl", ADDR_CTRL, 8'h00);
    chk_reg("mid_rst_status", ADDR_STATUS, 8'h00);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
